// File: rtl/prog_mode_counter_if.sv
// Control/status bundle for prog_mode_counter: the master drives the controls, the counter (slave) drives the status.
interface prog_mode_counter_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic [1:0]       mode;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] cmp_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             cmp_match;
    logic             running;

    modport master (
        output en, load, load_val, dir, mode, prescale, cmp_val,
        input  count, tc, cmp_match, running
    );

    modport slave (
        input  en, load, load_val, dir, mode, prescale, cmp_val,
        output count, tc, cmp_match, running
    );
endinterface

// File: rtl/prog_mode_counter.sv
// Loadable up/down counter with prescaler, four terminal-count modes,
// a compare output and a one-cycle terminal-count pulse.
module prog_mode_counter #(
    parameter int WIDTH      = 8,
    parameter int PRE_W      = 4,
    parameter bit RESET_LOAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prog_mode_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_EXPIRED = 1'b1
    } run_state_t;

    run_state_t       state_p0, state_nxt;
    logic [WIDTH-1:0] count_p0, count_nxt;
    logic [PRE_W-1:0] psc_p0,   psc_nxt;
    logic             tc_p0,    tc_nxt;
    logic             active;
    logic             tick;
    logic             at_term;

    // Count value taken on a terminal tick; saturate and one-shot both hold.
    function automatic logic [WIDTH-1:0] terminal_next(
        input logic [1:0]       m,
        input logic             d,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] lv
    );
        case (m)
            2'b00:   terminal_next = d ? MAX : '0;
            2'b01:   terminal_next = cur;
            2'b10:   terminal_next = cur;
            2'b11:   terminal_next = lv;
            default: terminal_next = cur;
        endcase
    endfunction

    assign active  = bus.en && (state_p0 == ST_RUN);
    // >= rather than == so lowering prescale below psc cannot stall the counter
    assign tick    = active && (psc_p0 >= bus.prescale);
    assign at_term = bus.dir ? (count_p0 == '0) : (count_p0 == MAX);

    always_comb begin
        state_nxt = state_p0;
        count_nxt = count_p0;
        psc_nxt   = psc_p0;
        tc_nxt    = 1'b0;
        if (bus.load) begin
            count_nxt = bus.load_val;
            psc_nxt   = '0;
            state_nxt = ST_RUN;
        end else if (tick) begin
            psc_nxt = '0;
            if (!at_term) begin
                count_nxt = bus.dir ? (count_p0 - WIDTH'(1)) : (count_p0 + WIDTH'(1));
            end else begin
                tc_nxt    = 1'b1;
                count_nxt = terminal_next(bus.mode, bus.dir, count_p0, bus.load_val);
                if (bus.mode == 2'b10) begin
                    state_nxt = ST_EXPIRED;
                end
            end
        end else if (active) begin
            psc_nxt = psc_p0 + PRE_W'(1);
        end
    end

    // Stage p0: single register stage holding all counter state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0 <= ST_RUN;
            count_p0 <= RESET_LOAD ? bus.load_val : '0;
            psc_p0   <= '0;
            tc_p0    <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            count_p0 <= count_nxt;
            psc_p0   <= psc_nxt;
            tc_p0    <= tc_nxt;
        end
    end

    assign bus.count     = count_p0;
    assign bus.tc        = tc_p0;
    assign bus.running   = (state_p0 == ST_RUN);
    assign bus.cmp_match = (count_p0 == bus.cmp_val);

endmodule
